axi_irom_responder: RTL and testbench
=====================================

# axi_irom_responder

AXI3 read-channel responder (slave) backed by a loadable word-addressed memory. It answers instruction-side burst and single reads, such as the 4-beat INCR line fills and single uncached fetches issued by the instruction cache's AXI read master. It sits at the slave end of the instruction read bus and serves as the bench and FPGA instruction memory. The block is read-only and has no AW/W/B channels.

## Interface
- ADDR_W, 12: log2 of memory depth in 32-bit words.
- BASE_ADDR, 32'h1FC0_0000: byte base address, aligned to 2^(ADDR_W+2).
- LATENCY, 2: idle cycles between AR handshake and first R beat (0..15).
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- arid  in  4  transaction ID.
- araddr  in  32  byte address; bits [1:0] ignored.
- arlen  in  4  beats-1.
- arsize  in  3  ignored; beats are always 4 bytes.
- arburst  in  2  00 FIXED, 01 INCR, others treated as INCR.
- arvalid  in  1  request valid.
- arready  out  1  request accept.
- rid  out  4  echoed arid.
- rdata  out  32  read word.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  final beat.
- rvalid  out  1  beat valid.
- rready  in  1  master accept.
- ld_en  in  1  preload write strobe.
- ld_addr  in  ADDR_W  preload word index.
- ld_data  in  32  preload word.

## Operation
- One outstanding transaction. The FSM has three states:
  - IDLE: arready=1. On arvalid&&arready, latch arid, araddr&~3, arlen and arburst, then go to WAIT if LATENCY>0, else BURST.
  - WAIT: a down-counter loaded with LATENCY-1 counts to 0, then goes to BURST.
  - BURST: rvalid=1, presenting the current beat.
- Beat accept is rvalid&&rready. On accept:
  - If beat count < len: increment beat count. The address advances by 4 for INCR and is unchanged for FIXED.
  - If beat count == len: go to IDLE.
- rlast=1 only when beat count == latched arlen.
- Range check is per beat:
  - In range means address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]. In range gives rdata = mem[address[ADDR_W+1:2]] and rresp=OKAY.
  - Out of range gives rdata=0 and rresp=SLVERR. The burst still completes with all arlen+1 beats.
- An INCR burst that crosses the top of the range switches to SLVERR at the crossing beat. The address arithmetic is 32-bit and wraps at 2^32.
- rid holds the latched arid for the whole burst.
- Preload: when ld_en=1, mem[ld_addr] <= ld_data at the clock edge. This is allowed in any state. A word that is already presented does not change; a later beat reads the new value.
- Memory contents are not reset.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, FSM=IDLE, counters=0.
- arready goes to 1 the first cycle after resetn is released.
- All outputs are registered.
- arready drops the cycle after the handshake. It reasserts the cycle after the last beat is accepted, so the minimum AR-to-AR spacing is LATENCY+len+3 cycles.
- The first rvalid appears 1+LATENCY cycles after the AR handshake edge.
- Back-to-back beats: with rready held at 1, one beat is accepted per cycle.
- Under rready=0, rvalid, rdata, rresp, rlast and rid hold stable until accept.
- rvalid never drops without an accept.
- arvalid while busy is ignored, because arready=0. The master must hold it.
- Reset asserted mid-burst abandons the transaction; the next edge restores all reset values.

## Structure
- Package axi_pkg holds:
  - BURST_FIXED and BURST_INCR.
  - RESP_OKAY and RESP_SLVERR.
  - FSM state enum {IDLE, WAIT, BURST}.
- Sub-module axi_irom_array contains 2^ADDR_W×32 storage with one synchronous write port (ld) and one asynchronous read port (current beat index).
- The responder holds the FSM, the address and beat counters, the latency counter and the output registers.

## Test plan
- Single read:
  - Stimulus: preload mem[0x10]=0xDEADBEEF; AR addr=BASE+0x40, len=0, id=2; LATENCY=2.
  - Response: one beat 3 cycles after the handshake with rdata=0xDEADBEEF, rlast=1, rid=2, rresp=OKAY.
- Line fill:
  - Stimulus: AR addr=BASE+0x100, len=3, INCR, id=3, with rready=1.
  - Response: 4 consecutive beats of mem[0x40..0x43]; rlast only on beat 3; arready back 1 cycle later.
- Backpressure:
  - Stimulus: same 4-beat burst, with rready=0 for 5 cycles at beat 1.
  - Response: beat 1 outputs hold unchanged; no beat is skipped or duplicated.
- FIXED burst and range errors:
  - FIXED len=2 at BASE+0x8 returns mem[2] three times.
  - INCR len=3 starting 8 bytes below the range top returns OKAY, OKAY, SLVERR(0), SLVERR(0).
- Reset and preload:
  - Stimulus: resetn=0 during beat 2, then an ld write to the word of a pending beat.
  - Response: all outputs are at reset values the next cycle and arready=1 after release. The later beat returns the newly loaded value.

Source files
------------

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared AXI3 read-channel encodings and responder FSM states.
// Revision : 1.0
// ============================================================================
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } irom_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_irom_array.sv
`default_nettype none
// ============================================================================
// Module   : axi_irom_array
// Purpose  : Word storage with a synchronous preload port and async read port.
// Revision : 1.0
// ============================================================================
module axi_irom_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [31:0]       i_ld_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_ld_en) begin
      r_mem[i_ld_addr] <= i_ld_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/axi_irom_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_irom_responder
// Purpose  : AXI3 read-only slave serving single and burst reads from memory.
// Revision : 1.0
// ============================================================================
module axi_irom_responder
  import axi_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
  parameter int          LATENCY   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_BURST = ST_BURST;
  localparam logic [3:0] c_lat_load = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [1:0]  r_burst;
  logic [3:0]  r_beat;
  logic [3:0]  r_lat;
  logic        r_arready;
  logic        r_rvalid;
  logic        r_rlast;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [31:0] w_next_addr;
  logic [31:0] w_rd_addr;
  logic [31:0] w_mem_data;
  logic        w_in_range;
  logic [31:0] w_beat_data;
  logic [1:0]  w_beat_resp;
  logic        w_last_beat;
  logic        w_unused;

  // Once a beat is on the bus, the array looks ahead so the next beat can be
  // registered on the same edge that accepts the current one.
  assign w_next_addr = r_addr + ((r_burst == BURST_FIXED) ? 32'd0 : 32'd4);
  assign w_rd_addr   = r_rvalid ? w_next_addr : r_addr;
  assign w_in_range  = (w_rd_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign w_beat_data = w_in_range ? w_mem_data : 32'd0;
  assign w_beat_resp = w_in_range ? RESP_OKAY : RESP_SLVERR;
  assign w_last_beat = (r_beat == r_len);
  assign w_unused    = &{1'b0, arsize, araddr[1:0]};

  axi_irom_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .i_ld_en   (ld_en),
    .i_ld_addr (ld_addr),
    .i_ld_data (ld_data),
    .i_rd_addr (w_rd_addr[ADDR_W+1:2]),
    .o_rd_data (w_mem_data)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_len     <= 4'd0;
      r_burst   <= 2'd0;
      r_beat    <= 4'd0;
      r_lat     <= 4'd0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= 4'd0;
      r_rdata   <= 32'd0;
      r_rresp   <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_arready <= 1'b1;
          if (arvalid && r_arready) begin
            r_arready <= 1'b0;
            r_rid     <= arid;
            r_addr    <= {araddr[31:2], 2'b00};
            r_len     <= arlen;
            r_burst   <= arburst;
            r_beat    <= 4'd0;
            r_lat     <= c_lat_load;
            r_state   <= (LATENCY > 0) ? S_WAIT : S_BURST;
          end
        end
        S_WAIT: begin
          if (r_lat == 4'd0) begin
            r_state <= S_BURST;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        S_BURST: begin
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rlast  <= w_last_beat;
          end else if (rready) begin
            if (w_last_beat) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_addr  <= w_next_addr;
              r_rdata <= w_beat_data;
              r_rresp <= w_beat_resp;
              r_rlast <= ((r_beat + 4'd1) == r_len);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_irom_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_irom_responder
// Purpose  : Randomized self-checking bench against a word-array reference.
// Revision : 1.0
// ============================================================================
module tb_axi_irom_responder;

  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h1FC0_0000;
  localparam int          LAT    = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model [DEPTH];

  axi_irom_responder #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .LATENCY   (LAT)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(idx);
    ld_data = data;
    tick();
    ld_en = 1'b0;
    model[idx] = data;
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == (BASE >> (ADDR_W + 2));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // reset_beat / ld_beat < 0 disables that event; stall_beat < 0 means none.
  task automatic run_read(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input int stall_beat, input int stall_len, input bit rnd_stall,
                          input int reset_beat, input int ld_beat);
    logic [31:0] ea [16];
    logic [31:0] ed [16];
    logic [1:0]  er [16];
    logic [63:0] held;
    int waited;
    int k;
    int widx;
    logic [31:0] nv;
    for (int b = 0; b <= int'(len); b++) begin
      ea[b] = {addr[31:2], 2'b00} + ((burst == 2'b00) ? 32'd0 : 32'(4 * b));
      if (in_range(ea[b])) begin
        ed[b] = model[word_of(ea[b])];
        er[b] = 2'b00;
      end else begin
        ed[b] = 32'd0;
        er[b] = 2'b10;
      end
    end
    waited = 0;
    while (!arready && waited < 40) begin
      tick();
      waited++;
    end
    if (!arready) begin
      check("arready_timeout", 64'(arready), 64'd1);
      return;
    end
    arid = id; araddr = addr; arlen = len; arburst = burst;
    arsize = 3'($urandom); arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    araddr  = $urandom;
    arid    = 4'($urandom);
    check("arready_drop", 64'(arready), 64'd0);
    for (int b = 0; b <= int'(len); b++) begin
      waited = 0;
      while (!rvalid && waited < 40) begin
        tick();
        waited++;
      end
      if (b == 0) check("first_latency", 64'(waited), 64'(1 + LAT));
      else        check("beat_gap", 64'(waited), 64'd0);
      if (!rvalid) return;
      check("rdata", 64'(rdata), 64'(ed[b]));
      check("rresp", 64'(rresp), 64'(er[b]));
      check("rlast", 64'(rlast), 64'(b == int'(len)));
      check("rid", 64'(rid), 64'(id));
      if (b == reset_beat) begin
        resetn = 1'b0;
        tick();
        check("reset_outputs", {arready, rvalid, rlast, rid, rresp, rdata},
              64'd0);
        resetn = 1'b1;
        tick();
        check("arready_after_reset", 64'(arready), 64'd1);
        return;
      end
      held = {rvalid, rlast, rid, rresp, rdata};
      if (b == 0 && ld_beat >= 0) begin
        rready  = 1'b0;
        widx    = word_of(ea[ld_beat]);
        nv      = $urandom;
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(widx);
        ld_data = nv;
        tick();
        ld_en = 1'b0;
        model[widx] = nv;
        for (int j = 1; j <= int'(len); j++)
          if (in_range(ea[j]) && word_of(ea[j]) == widx) ed[j] = nv;
        check("hold_after_ld", {rvalid, rlast, rid, rresp, rdata}, held);
      end
      k = (b == stall_beat) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      if (k > 0) begin
        rready = 1'b0;
        repeat (k) begin
          tick();
          check("hold_stall", {rvalid, rlast, rid, rresp, rdata}, held);
        end
      end
      rready = 1'b1;
      tick();
    end
    check("arready_back", 64'(arready), 64'd1);
    check("rvalid_off", 64'(rvalid), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    resetn = 1'b0; rready = 1'b1; arvalid = 1'b0; arid = '0; araddr = '0;
    arlen = '0; arsize = 3'd2; arburst = 2'b01; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    check("reset_outputs", {arready, rvalid, rlast, rid, rresp, rdata}, 64'd0);
    resetn = 1'b1;
    tick();
    check("arready_after_release", 64'(arready), 64'd1);

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    load(32'h10, 32'hDEAD_BEEF);

    run_read(4'd2, BASE + 32'h40,   4'd0, 2'b01, -1, 0, 1'b0, -1, -1);
    run_read(4'd3, BASE + 32'h100,  4'd3, 2'b01, -1, 0, 1'b0, -1, -1);
    run_read(4'd3, BASE + 32'h100,  4'd3, 2'b01,  1, 5, 1'b0, -1, -1);
    run_read(4'd6, BASE + 32'h8,    4'd2, 2'b00, -1, 0, 1'b0, -1, -1);
    run_read(4'd7, BASE + 32'h3FF8, 4'd3, 2'b01, -1, 0, 1'b0, -1, -1);
    run_read(4'd8, 32'h0000_1000,   4'd1, 2'b10, -1, 0, 1'b0, -1, -1);
    run_read(4'd9, 32'hFFFF_FFF8,   4'd3, 2'b01, -1, 0, 1'b0, -1, -1);
    run_read(4'd4, BASE + 32'h200,  4'd3, 2'b01, -1, 0, 1'b0,  2, -1);
    run_read(4'd5, BASE + 32'h300,  4'd3, 2'b01, -1, 0, 1'b0, -1,  2);
    run_read(4'd1, BASE + 32'h20,   4'd2, 2'b00, -1, 0, 1'b0, -1,  0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        1: a = BASE + 32'(DEPTH * 4) - 32'(4 * $urandom_range(1, 8));
        2: a = $urandom;
        default: a = BASE + 32'(4 * $urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, DEPTH - 1)), $urandom);
      run_read(4'($urandom), a, 4'($urandom), 2'($urandom), -1, 0, 1'b1, -1,
               ($urandom_range(0, 4) == 0) ? 0 : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
